// File: rtl/matmult_pkg.sv
// Shared types and constants for the streaming 2x2 Strassen multiplier.
package matmult_pkg;

    localparam int unsigned DEF_IN_W  = 16;
    localparam int unsigned DEF_OUT_W = 32;

    localparam int unsigned N_OPND = 8;
    localparam int unsigned N_RES  = 4;

    // Operand positions on the input stream and in the operand register file
    localparam int unsigned A11 = 0;
    localparam int unsigned A12 = 1;
    localparam int unsigned A21 = 2;
    localparam int unsigned A22 = 3;
    localparam int unsigned B11 = 4;
    localparam int unsigned B12 = 5;
    localparam int unsigned B21 = 6;
    localparam int unsigned B22 = 7;

    // Result positions on the output stream
    localparam int unsigned C11 = 0;
    localparam int unsigned C12 = 1;
    localparam int unsigned C21 = 2;
    localparam int unsigned C22 = 3;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/strassen2x2_core.sv
// Two-stage 2x2 Strassen datapath: stage 1 registers M1..M7, stage 2 the four sums.
// Free-running with no control or reset; the caller decides when results are valid.
module strassen2x2_core #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic                    clk,
    input  logic signed [IN_W-1:0]  a11_i,
    input  logic signed [IN_W-1:0]  a12_i,
    input  logic signed [IN_W-1:0]  a21_i,
    input  logic signed [IN_W-1:0]  a22_i,
    input  logic signed [IN_W-1:0]  b11_i,
    input  logic signed [IN_W-1:0]  b12_i,
    input  logic signed [IN_W-1:0]  b21_i,
    input  logic signed [IN_W-1:0]  b22_i,
    output logic signed [OUT_W-1:0] c11_o,
    output logic signed [OUT_W-1:0] c12_o,
    output logic signed [OUT_W-1:0] c21_o,
    output logic signed [OUT_W-1:0] c22_o
);

    localparam int unsigned SUM_W  = IN_W + 1;
    localparam int unsigned PROD_W = 2 * IN_W + 2;
    localparam int unsigned RES_W  = 2 * IN_W + 3;

    logic signed [SUM_W-1:0]  mul_x [7];
    logic signed [SUM_W-1:0]  mul_y [7];
    logic signed [PROD_W-1:0] m_d   [7];
    logic signed [PROD_W-1:0] m_q   [7];
    logic signed [RES_W-1:0]  r11_d, r12_d, r21_d, r22_d;
    logic signed [OUT_W-1:0]  c11_q, c12_q, c21_q, c22_q;

    // Operand sums/differences feeding the seven Strassen multipliers
    always_comb begin
        mul_x[0] = SUM_W'(a11_i) + SUM_W'(a22_i);
        mul_y[0] = SUM_W'(b11_i) + SUM_W'(b22_i);
        mul_x[1] = SUM_W'(a21_i) + SUM_W'(a22_i);
        mul_y[1] = SUM_W'(b11_i);
        mul_x[2] = SUM_W'(a11_i);
        mul_y[2] = SUM_W'(b12_i) - SUM_W'(b22_i);
        mul_x[3] = SUM_W'(a22_i);
        mul_y[3] = SUM_W'(b21_i) - SUM_W'(b11_i);
        mul_x[4] = SUM_W'(a11_i) + SUM_W'(a12_i);
        mul_y[4] = SUM_W'(b22_i);
        mul_x[5] = SUM_W'(a21_i) - SUM_W'(a11_i);
        mul_y[5] = SUM_W'(b11_i) + SUM_W'(b12_i);
        mul_x[6] = SUM_W'(a12_i) - SUM_W'(a22_i);
        mul_y[6] = SUM_W'(b21_i) + SUM_W'(b22_i);
        for (int k = 0; k < 7; k++) begin
            m_d[k] = PROD_W'(mul_x[k]) * PROD_W'(mul_y[k]);
        end
    end

    // Result sums at full precision before narrowing to OUT_W
    always_comb begin
        r11_d = RES_W'(m_q[0]) + RES_W'(m_q[3]) - RES_W'(m_q[4]) + RES_W'(m_q[6]);
        r12_d = RES_W'(m_q[2]) + RES_W'(m_q[4]);
        r21_d = RES_W'(m_q[1]) + RES_W'(m_q[3]);
        r22_d = RES_W'(m_q[0]) - RES_W'(m_q[1]) + RES_W'(m_q[2]) + RES_W'(m_q[5]);
    end

    // Pipeline registers: products, then narrowed results
    always_ff @(posedge clk) begin
        m_q   <= m_d;
        c11_q <= OUT_W'(r11_d);
        c12_q <= OUT_W'(r12_d);
        c21_q <= OUT_W'(r21_d);
        c22_q <= OUT_W'(r22_d);
    end

    assign c11_o = c11_q;
    assign c12_o = c12_q;
    assign c21_o = c21_q;
    assign c22_o = c22_q;

endmodule

// File: rtl/matmult_stream.sv
// Serial valid/ready wrapper around strassen2x2_core: loads 8 operands, waits
// out the 2-stage core, then streams 4 results. Optional MATMULT_STREAM_CHECK_EN
// adds a naive 2x2 product compared against the Strassen result (sticky chk_err).
module matmult_stream
    import matmult_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef MATMULT_STREAM_CHECK_EN
    ,
    output logic             chk_err
`endif
);

    state_e                  state_q, state_d;
    logic [2:0]              ld_cnt_q, ld_cnt_d;
    logic [1:0]              ul_cnt_q, ul_cnt_d;
    logic                    cmp_cnt_q, cmp_cnt_d;
    logic                    in_ready_q, out_valid_q;
    logic                    in_fire, out_fire;
    logic signed [IN_W-1:0]  opnd_q [N_OPND];
    logic signed [OUT_W-1:0] c11, c12, c21, c22;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state and counter logic
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        ul_cnt_d  = ul_cnt_q;
        cmp_cnt_d = cmp_cnt_q;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    if (ld_cnt_q == 3'd7) begin
                        ld_cnt_d = 3'd0;
                        state_d  = COMPUTE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 3'd1;
                    end
                end
            end
            COMPUTE: begin
                if (cmp_cnt_q) begin
                    cmp_cnt_d = 1'b0;
                    state_d   = UNLOAD;
                end else begin
                    cmp_cnt_d = 1'b1;
                end
            end
            UNLOAD: begin
                if (out_fire) begin
                    if (ul_cnt_q == 2'd3) begin
                        ul_cnt_d = 2'd0;
                        state_d  = LOAD;
                    end else begin
                        ul_cnt_d = ul_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State, counters and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            ld_cnt_q    <= 3'd0;
            ul_cnt_q    <= 2'd0;
            cmp_cnt_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            ul_cnt_q    <= ul_cnt_d;
            cmp_cnt_q   <= cmp_cnt_d;
            in_ready_q  <= (state_d == LOAD);
            out_valid_q <= (state_d == UNLOAD);
        end
    end

    // Operand register file, written one accepted beat at a time
    always_ff @(posedge clk) begin
        if (in_fire) begin
            opnd_q[ld_cnt_q] <= $signed(in_data);
        end
    end

    strassen2x2_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .clk   (clk),
        .a11_i (opnd_q[A11]),
        .a12_i (opnd_q[A12]),
        .a21_i (opnd_q[A21]),
        .a22_i (opnd_q[A22]),
        .b11_i (opnd_q[B11]),
        .b12_i (opnd_q[B12]),
        .b21_i (opnd_q[B21]),
        .b22_i (opnd_q[B22]),
        .c11_o (c11),
        .c12_o (c12),
        .c21_o (c21),
        .c22_o (c22)
    );

    // Result select: a mux over the core's stage-2 registers
    always_comb begin
        out_data = c11;
        case (ul_cnt_q)
            2'(C12): out_data = c12;
            2'(C21): out_data = c21;
            2'(C22): out_data = c22;
            default: out_data = c11;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

`ifdef MATMULT_STREAM_CHECK_EN
    localparam int unsigned RES_W = 2 * IN_W + 3;

    logic signed [OUT_W-1:0] n11_q, n12_q, n21_q, n22_q;
    logic                    chk_err_q;
    logic                    mismatch;

    // Naive product, registered alongside core stage 2 (operands are stable then)
    always_ff @(posedge clk) begin
        n11_q <= OUT_W'(RES_W'(opnd_q[A11]) * RES_W'(opnd_q[B11]) + RES_W'(opnd_q[A12]) * RES_W'(opnd_q[B21]));
        n12_q <= OUT_W'(RES_W'(opnd_q[A11]) * RES_W'(opnd_q[B12]) + RES_W'(opnd_q[A12]) * RES_W'(opnd_q[B22]));
        n21_q <= OUT_W'(RES_W'(opnd_q[A21]) * RES_W'(opnd_q[B11]) + RES_W'(opnd_q[A22]) * RES_W'(opnd_q[B21]));
        n22_q <= OUT_W'(RES_W'(opnd_q[A21]) * RES_W'(opnd_q[B12]) + RES_W'(opnd_q[A22]) * RES_W'(opnd_q[B22]));
    end

    assign mismatch = (n11_q != c11) || (n12_q != c12) || (n21_q != c21) || (n22_q != c22);

    // Sticky error flag, evaluated while results are held for unload
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_err_q <= 1'b0;
        end else if (state_q == UNLOAD && mismatch) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_matmult_stream.sv
// Bench for matmult_stream: directed vector table, random stream with
// back-pressure, reset aborts, and (with MATMULT_STREAM_CHECK_EN) the self-check.
module tb_matmult_stream;

    localparam int TMO = 2000;

    typedef struct {
        logic [7:0][15:0] op;
        logic [3:0][31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef MATMULT_STREAM_CHECK_EN
    logic        chk_err;
`endif

    matmult_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MATMULT_STREAM_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rdy_pct = 100;
    int          gap_pct = 0;
    int          ov_rise_cyc = -1;
    int          e_first = 0;
    int          e_last = 0;
    logic [31:0] sb [$];
    logic        prev_ov = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [7:0][15:0] o, input int k);
        longint a11 = longint'($signed(o[0]));
        longint a12 = longint'($signed(o[1]));
        longint a21 = longint'($signed(o[2]));
        longint a22 = longint'($signed(o[3]));
        longint b11 = longint'($signed(o[4]));
        longint b12 = longint'($signed(o[5]));
        longint b21 = longint'($signed(o[6]));
        longint b22 = longint'($signed(o[7]));
        longint r;
        case (k)
            0:       r = a11 * b11 + a12 * b21;
            1:       r = a11 * b12 + a12 * b22;
            2:       r = a21 * b11 + a22 * b21;
            default: r = a21 * b12 + a22 * b22;
        endcase
        return 32'(r);
    endfunction

    function automatic vec_t mk(input int o0, input int o1, input int o2, input int o3,
                                input int o4, input int o5, input int o6, input int o7,
                                input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.op[0] = 16'(o0); v.op[1] = 16'(o1); v.op[2] = 16'(o2); v.op[3] = 16'(o3);
        v.op[4] = 16'(o4); v.op[5] = 16'(o5); v.op[6] = 16'(o6); v.op[7] = 16'(o7);
        v.exp[0] = 32'(e0); v.exp[1] = 32'(e1); v.exp[2] = 32'(e2); v.exp[3] = 32'(e3);
        return v;
    endfunction

    // Output monitor: scoreboard compare on each accepted beat, stability while stalled
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_ov    = 1'b0;
        end else begin
            if (out_valid && !prev_ov && ov_rise_cyc < 0) ov_rise_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid_held", 32'(out_valid), 32'd1);
                check("stall_data_held", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat: got %0d with no result pending", $signed(out_data));
                end else begin
                    check("result", out_data, sb.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_ov    = out_valid;
        end
    end

    // Sink readiness, redrawn each cycle
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (int'($urandom_range(99)) < rdy_pct);
        end
    end

    task automatic drive(input logic [7:0][15:0] ops, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = ops[i];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < TMO);
            if (!in_ready) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout: beat %0d never accepted", i);
            end
            @(posedge clk);
            #1;
            if (i == 0) e_first = cyc;
            e_last   = cyc;
            in_valid = 1'b0;
            in_data  = 16'($urandom);
        end
    endtask

    task automatic push_vec(input vec_t v);
        for (int k = 0; k < 4; k++) sb.push_back(v.exp[k]);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 4 * TMO) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    vec_t             vt [6];
    logic [7:0][15:0] rops;
    vec_t             rv;
    int               e1_0, e8_0, t;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
`ifdef MATMULT_STREAM_CHECK_EN
        check("reset_chk_err", 32'(chk_err), 32'd0);
`endif
        @(posedge clk);
        #1;

        vt[0] = mk(0, 1, 2, 3, 4, 5, 6, 7, 6, 7, 26, 31);
        vt[1] = mk(-32768, 32767, -1, 1, -32768, -32768, 32767, 2, 2147418113, 1073807358, 65535, 32770);
        vt[2] = mk(1, 0, 0, 1, 9, 8, 7, 6, 9, 8, 7, 6);
        vt[3] = mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                   2147352578, 2147352578, 2147352578, 2147352578);
        vt[4] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                   -2147483647 - 1, -2147483647 - 1, -2147483647 - 1, -2147483647 - 1);
        vt[5] = mk(-1, 2, 3, -4, 5, -6, -7, 8, -19, 22, 43, -50);

        // Directed table, both sides always ready; timing measured on the first two sets
        rdy_pct = 100;
        gap_pct = 0;
        for (int i = 0; i < 6; i++) begin
            push_vec(vt[i]);
            drive(vt[i].op, 8);
            if (i == 0) begin
                e1_0 = e_first;
                e8_0 = e_last;
            end
            if (i == 1) begin
                check("first_out_valid_latency", 32'(ov_rise_cyc - e8_0), 32'd2);
                check("turnaround_cycles", 32'(e_first - e1_0), 32'd14);
            end
        end
        drain();
`ifdef MATMULT_STREAM_CHECK_EN
        check("chk_err_clean_table", 32'(chk_err), 32'd0);
`endif

        // Same table with input gaps and output back-pressure
        gap_pct = 50;
        rdy_pct = 30;
        for (int i = 0; i < 6; i++) begin
            push_vec(vt[i]);
            drive(vt[i].op, 8);
        end
        drain();

        // Random operand sets, extremes mixed in
        for (int s = 0; s < 200; s++) begin
            for (int j = 0; j < 8; j++) begin
                case ($urandom_range(9))
                    0:       rops[j] = 16'h8000;
                    1:       rops[j] = 16'h7fff;
                    2:       rops[j] = 16'hffff;
                    default: rops[j] = 16'($urandom);
                endcase
            end
            for (int k = 0; k < 4; k++) sb.push_back(model(rops, k));
            drive(rops, 8);
        end
        drain();
        repeat (20) @(negedge clk);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
`ifdef MATMULT_STREAM_CHECK_EN
        check("chk_err_clean_random", 32'(chk_err), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Reset after operand 5, then an identity-A set must come out untouched
        gap_pct = 0;
        rdy_pct = 100;
        drive(vt[5].op, 5);
        pulse_reset();
        @(negedge clk);
        check("abort_load_in_ready", 32'(in_ready), 32'd1);
        check("abort_load_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        push_vec(vt[2]);
        drive(vt[2].op, 8);
        drain();

        // Reset during unload right after c12 is accepted
        push_vec(vt[5]);
        drive(vt[5].op, 8);
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (sb.size() > 2 && t < TMO);
        check("unload_reached_c12", 32'(sb.size()), 32'd2);
        @(posedge clk);
        #1;
        pulse_reset();
        @(negedge clk);
        check("abort_unload_out_valid", 32'(out_valid), 32'd0);
        check("abort_unload_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        push_vec(vt[0]);
        drive(vt[0].op, 8);
        drain();

`ifdef MATMULT_STREAM_CHECK_EN
        // Corrupt one Strassen result; chk_err must latch and survive a clean set
        force dut.u_core.c11_q = 32'h0000_1234;
        rv = vt[0];
        rv.exp[0] = 32'h0000_1234;
        push_vec(rv);
        drive(vt[0].op, 8);
        drain();
        check("chk_err_set", 32'(chk_err), 32'd1);
        release dut.u_core.c11_q;
        push_vec(vt[5]);
        drive(vt[5].op, 8);
        drain();
        check("chk_err_sticky", 32'(chk_err), 32'd1);
        pulse_reset();
        @(negedge clk);
        check("chk_err_cleared", 32'(chk_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
